pio_input_edge_irq: RTL



---
 rtl/pio_input_edge_irq.sv | 119 +++++++++++
 1 files changed

// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: synchronised, debounced inputs with per-bit edge capture and masked level irq.
// Register map: 0 data (debounced), 1 irq mask, 2 reserved (reads 0), 3 edge capture (write-1-to-clear).
module pio_input_edge_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_mux;
  logic             wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      always_ff @(posedge clk) begin
        if (reset) stable <= '0;
        else       stable <= sync;
      end
    end else begin : g_debounce
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt [WIDTH];

      // Any return to the accepted value restarts the count from zero.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              stable[i] <= sync[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  assign rise     = stable & ~prev;
  assign fall     = ~stable & prev;
  assign edge_det = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign wr_en    = chipselect & ~write_n;
  assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // A new edge in the same cycle as its clear wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
    end else begin
      prev         <= stable;
      edge_capture <= (edge_capture & ~clr_bits) | edge_det;
      if (wr_en && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
      readdata     <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  generate
    if (WIDTH < 32) begin : g_hi_unused
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule
